// File: rtl/mem_port_arbiter.sv
// Shares one single-ported sync memory between IF and D; grant-to-rvalid latency MEM_LAT+1, one access in flight.
// Requesters hold req until gnt. ARB_RR_EN selects round-robin on ties; default is fixed D-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_win;
`ifdef ARB_RR_EN
  owner_t            last_owner_q, last_owner_d;

  // On a tie, the side not granted last time goes first.
  assign d_win = d_req && (!if_req || (last_owner_q == OWN_IF));
`else
  assign d_win = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_we      = 4'b0000;
    mem_wdata   = '0;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        // rst_n gating keeps the port quiet while reset is asserted.
        if (rst_n && (if_req || d_req)) begin
          mem_en  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          if (d_win) begin
            d_gnt     = 1'b1;
            mem_addr  = d_addr;
            mem_we    = d_wmask;
            mem_wdata = d_wdata;
            owner_d   = OWN_D;
            is_wr_d   = (d_wmask != 4'b0000);
          end else begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
            owner_d  = OWN_IF;
            is_wr_d  = 1'b0;
          end
`ifdef ARB_RR_EN
          last_owner_d = owner_d;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!is_wr_q) d_rdata_d = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      is_wr_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2; inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  int total = 0;
  int bad   = 0;
  int n_d, n_if, n_g;
  logic [3:0] order;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then sample at the following falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h0; d_addr = 32'h0; d_wmask = 4'b0; d_wdata = 32'h0; mem_rdata = 32'h0;

    // 1: reset holds everything quiet despite requests
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
      chk("rst_en_rv", {29'b0, mem_en, if_rvalid, d_rvalid}, 32'h0);
    end
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    tick(); d_addr = 32'h80; rst_n = 1'b1;
    sample();
    chk("post_rst_dgnt", {30'b0, if_gnt, d_gnt}, 32'h1);
    chk("post_rst_addr", mem_addr, 32'h80);
    tick(); d_req = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 2: IF read 0x100
    if_req = 1'b1; if_addr = 32'h100;
    sample();
    chk("t2_gnt", {30'b0, if_gnt, d_gnt}, 32'h2);
    chk("t2_en", {31'b0, mem_en}, 32'h1);
    chk("t2_addr", mem_addr, 32'h100);
    chk("t2_we", {28'b0, mem_we}, 32'h0);
    tick(); if_req = 1'b0;
    sample(); chk("t2_T1_en_rv", {30'b0, mem_en, if_rvalid}, 32'h0);
    tick(); mem_rdata = 32'hDEADBEEF;
    sample(); chk("t2_T2_rv", {31'b0, if_rvalid}, 32'h0);
    tick(); mem_rdata = 32'h0;
    sample();
    chk("t2_T3_rv", {31'b0, if_rvalid}, 32'h1);
    chk("t2_T3_data", if_rdata, 32'hDEADBEEF);
    tick();
    sample();
    chk("t2_T4_rv", {31'b0, if_rvalid}, 32'h0);
    chk("t2_T4_data", if_rdata, 32'hDEADBEEF);

    // 3: D read and IF fetch contend
    tick(); d_req = 1'b1; d_addr = 32'h200; d_wmask = 4'b0; if_req = 1'b1; if_addr = 32'h104;
    sample();
    chk("t3_T0_gnt", {30'b0, if_gnt, d_gnt}, 32'h1);
    chk("t3_T0_addr", mem_addr, 32'h200);
    tick(); d_req = 1'b0;
    sample(); chk("t3_T1_wait", {29'b0, if_gnt, d_gnt, mem_en}, 32'h0);
    tick(); mem_rdata = 32'hA5A50001;
    sample(); chk("t3_T2_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
    tick(); mem_rdata = 32'h0;
    sample();
    chk("t3_T3_drv", {31'b0, d_rvalid}, 32'h1);
    chk("t3_T3_ddata", d_rdata, 32'hA5A50001);
    chk("t3_T3_ifgnt", {30'b0, if_gnt, d_gnt}, 32'h2);
    chk("t3_T3_addr", mem_addr, 32'h104);
    tick(); if_req = 1'b0;
    sample(); chk("t3_T4_rv", {30'b0, if_rvalid, d_rvalid}, 32'h0);
    tick(); mem_rdata = 32'h0BADF00D;
    sample(); chk("t3_T5_rv", {31'b0, if_rvalid}, 32'h0);
    tick(); mem_rdata = 32'h0;
    sample();
    chk("t3_T6_rv", {30'b0, if_rvalid, d_rvalid}, 32'h2);
    chk("t3_T6_data", if_rdata, 32'h0BADF00D);

    // 4: store leaves d_rdata alone
    tick(); d_req = 1'b1; d_addr = 32'h300; d_wmask = 4'b0011; d_wdata = 32'h1234;
    sample();
    chk("t4_gnt", {30'b0, if_gnt, d_gnt}, 32'h1);
    chk("t4_we", {28'b0, mem_we}, 32'h3);
    chk("t4_wdata", mem_wdata, 32'h1234);
    chk("t4_addr", mem_addr, 32'h300);
    tick(); d_req = 1'b0; d_wmask = 4'b0;
    tick(); mem_rdata = 32'hFFFFFFFF;
    tick(); mem_rdata = 32'h0;
    sample();
    chk("t4_T3_drv", {31'b0, d_rvalid}, 32'h1);
    chk("t4_T3_ddata", d_rdata, 32'hA5A50001);

    // 5: reset pulse mid-transaction discards the response
    tick(); tick(); if_req = 1'b1; if_addr = 32'h400;
    sample(); chk("t5_T0_gnt", {30'b0, if_gnt, d_gnt}, 32'h2);
    tick(); if_req = 1'b0;
    sample(); rst_n = 1'b0; #1 rst_n = 1'b1;
    n_g = 0;
    tick(); mem_rdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      sample(); n_g += int'(if_rvalid) + int'(d_rvalid) + int'(mem_en);
      tick(); mem_rdata = 32'h0;
    end
    chk("t5_no_rv", n_g, 32'h0);
    chk("t5_rdata_clr", if_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h500;
    sample();
    chk("t5_re_gnt", {30'b0, if_gnt, d_gnt}, 32'h2);
    chk("t5_re_addr", mem_addr, 32'h500);
    tick(); if_req = 1'b0;
    tick(); mem_rdata = 32'h22222222;
    sample(); chk("t5_re_T2_rv", {31'b0, if_rvalid}, 32'h0);
    tick(); mem_rdata = 32'h0;
    sample();
    chk("t5_re_T3_rv", {31'b0, if_rvalid}, 32'h1);
    chk("t5_re_T3_data", if_rdata, 32'h22222222);

    // 6: both held high for 12 cycles
    tick(); tick();
    d_req = 1'b1; if_req = 1'b1; d_addr = 32'h600; d_wmask = 4'b0; if_addr = 32'h700;
    n_d = 0; n_if = 0; n_g = 0; order = 4'b0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (d_gnt || if_gnt) begin
        if (n_g < 4) order[n_g] = d_gnt;
        n_g++;
      end
      n_d  += int'(d_gnt);
      n_if += int'(if_gnt);
      tick();
    end
    d_req = 1'b0; if_req = 1'b0;
`ifdef ARB_RR_EN
    chk("t6_d_cnt", n_d, 32'd2);
    chk("t6_if_cnt", n_if, 32'd2);
    chk("t6_order", {28'b0, order}, 32'h5);
`else
    chk("t6_d_cnt", n_d, 32'd4);
    chk("t6_if_cnt", n_if, 32'd0);
    chk("t6_order", {28'b0, order}, 32'hF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
